xor_serial_arbiter: RTL
=======================

// Module: xor_serial_arbiter
// PURPOSE
//   Shares one xor_gate instance among NREQ requesters; computes WIDTH-bit A^B bit-serially, LSB first, one bit per clk.
//   Sits between requester blocks and the single gate datapath; serialises access and returns each result tagged with its requester ID.
// PARAMETERS
//   NREQ   4  number of requesters (>=2)
//   WIDTH  8  operand/result width in bits (>=1)
//   IDW    $clog2(NREQ)  localparam, width of requester ID
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   req_valid  in   NREQ        per-requester operand valid
//   req_ready  out  NREQ        one-hot accept; at most one bit high
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   rsp_valid  out  1           result valid
//   rsp_ready  in   1           consumer accepts result
//   rsp_data   out  WIDTH       A^B of granted request
//   rsp_id     out  IDW         index of requester that produced rsp_data
//   busy       out  1           high in SHIFT or DONE
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, cnt=0, rr_ptr=0, shift regs=0; outputs rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0.
//   FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: grant = chosen index among req_valid (see CONFIGURATION); req_ready[grant]=1 combinationally, same cycle.
//     Handshake on edge where req_valid[g]&req_ready[g]: latch a/b into shift regs, rsp_id<=g, cnt<=0, -> SHIFT.
//     No req_valid: stay IDLE, req_ready all 0.
//   SHIFT: req_ready=0. Each edge: xor_gate(a_sr[0], b_sr[0]) shifted into res_sr MSB; a_sr/b_sr shift right; cnt++.
//     On edge with cnt==WIDTH-1 -> DONE. rsp_valid rises after the WIDTH-th edge following the accept edge.
//   DONE: rsp_valid=1; rsp_data, rsp_id stable until rsp_valid&rsp_ready edge, then -> IDLE, rsp_valid=0.
//     Min period: WIDTH+2 cycles per transaction (no accept in DONE).
//   Boundaries:
//     WIDTH=1: single SHIFT cycle.
//     req_valid dropped while not granted: legal, no effect.
//     req_valid of granted requester dropping after accept: no effect (operands latched).
//     rsp_ready high before DONE: ignored.
//     rst_n asserted mid-SHIFT/DONE: in-flight result discarded, no rsp_valid pulse; full reset state.
//     rr_ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//   Macro XOR_ARB_ROUND_ROBIN_EN:
//     defined: round-robin; search starts at rr_ptr; on accept rr_ptr <= (grant+1) mod NREQ.
//     undefined: fixed priority, lowest valid index wins; rr_ptr logic not built; starvation of high indices is permitted.
// STRUCTURE
//   Shared package xor_arb_pkg: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2), clog2 helper for IDW.
//   One sub-module: existing xor_gate(a, b, out), instantiated once as the shared bit datapath.
//   Grant select is a local combinational function; no further sub-modules.
// TESTING (NREQ=4, WIDTH=8)
//   1. rst_n=0 during activity -> all outputs 0 immediately, busy=0; release -> IDLE, no spurious req_ready.
//   2. req0 a=8'hA5 b=8'h0F -> req_ready[0] same cycle; rsp_data=8'hAA, rsp_id=0, rsp_valid after 8th edge after accept.
//   3. req_valid=4'b1111 held, rsp_ready=1 -> with macro: rsp_id sequence 0,1,2,3,0; without macro: 0,0,0,0,0.
//   4. rsp_ready=0 for 5 cycles in DONE -> rsp_valid/data/id held constant; req_ready stays 4'b0000; busy=1.
//   5. rst_n pulsed at 3rd SHIFT cycle of req1 -> no rsp_valid; then req3 a=8'hFF b=8'h00 -> rsp_data=8'hFF, rsp_id=3.
//   6. req2 a=b=8'hFF -> rsp_data=8'h00, rsp_id=2; compare every result against a^b reference model.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared definitions for the bit-serial XOR arbiter.
//   state_t : FSM state encodings (IDLE, SHIFT, DONE)
//   clog2   : ceiling log2 used to size the requester ID and bit counter.
//             It never returns less than 1, so a degenerate range still
//             yields a legal one-bit vector.
package xor_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Single-bit XOR gate. This is the one shared bit datapath that the
// arbiter time-multiplexes between its requesters.
//   a   in  1  operand bit A
//   b   in  1  operand bit B
//   out out 1  a ^ b
module xor_gate (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a ^ b;

endmodule

// File: rtl/xor_serial_arbiter.sv
// Shares one xor_gate among NREQ requesters. A granted request has its
// operands latched and its WIDTH-bit A^B computed one bit per clock, LSB
// first; the result is returned tagged with the requester index.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   req_valid  in   NREQ         per-requester operand valid
//   req_ready  out  NREQ         one-hot accept, only while idle
//   req_a      in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   operand B, same packing
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            consumer accepts the result
//   rsp_data   out  WIDTH        A^B of the granted request
//   rsp_id     out  IDW          index of the requester that produced rsp_data
//   busy       out  1            high while a request is shifting or waiting
//
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both high. req_ready is a combinational function of req_valid while
// idle; rsp_valid stays high with data/id frozen until rsp_ready is seen.
//
// Configuration macro XOR_ARB_ROUND_ROBIN_EN:
//   defined   - round-robin grant, search starts at rr_ptr, which moves to
//               one past the winner on every accept
//   undefined - fixed priority, lowest valid index wins
module xor_serial_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    // Counter holds 0..WIDTH so it can count the full operand width.
    localparam int CNTW = clog2(WIDTH + 1);

    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_next;
    logic [IDW-1:0]     grant;
    logic               any_valid;
    logic               gate_bit;

`ifdef XOR_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]     rr_ptr;

    // First valid index at or after start, wrapping around.
    function automatic logic [IDW-1:0] pick_grant(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  start
    );
        logic [IDW-1:0] g;
        logic           found;
        int             idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(start) + k) % NREQ;
            if (!found && valid[idx]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign grant = pick_grant(req_valid, rr_ptr);
`else
    // Lowest valid index wins; scanning downwards leaves the lowest last.
    function automatic logic [IDW-1:0] pick_grant(
        input logic [NREQ-1:0] valid
    );
        logic [IDW-1:0] g;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                g = IDW'(k);
            end
        end
        return g;
    endfunction

    assign grant = pick_grant(req_valid);
`endif

    assign any_valid = |req_valid;

    // Grant is offered only while idle and out of reset, so nothing is
    // advertised as accepted while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == ST_IDLE && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    xor_gate u_gate (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .out (gate_bit)
    );

    // Result fills from the MSB end so that after WIDTH shifts the first
    // (LSB) result bit has arrived at bit 0. Written this way so WIDTH=1
    // needs no special slice.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = gate_bit;
    end

    assign rsp_data = res_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef XOR_ARB_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        a_sr   <= req_a[int'(grant) * WIDTH +: WIDTH];
                        b_sr   <= req_b[int'(grant) * WIDTH +: WIDTH];
                        rsp_id <= grant;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
`ifdef XOR_ARB_ROUND_ROBIN_EN
                        rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
`endif
                    end
                end
                ST_SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
